// File: rtl/ex_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ex_mem_pkg                                                             |
// | Shared encodings for the EX/MEM stage: ALU ops, divide ops, store      |
// | sizes, branch compare kinds, result select and divider FSM states.     |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package ex_mem_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        DIV_DIV  = 2'd0,
        DIV_DIVU = 2'd1,
        DIV_REM  = 2'd2,
        DIV_REMU = 2'd3
    } div_op_e;

    typedef enum logic [2:0] {
        ST_NONE = 3'd0,
        ST_B    = 3'd1,
        ST_H    = 3'd2,
        ST_W    = 3'd3,
        ST_D    = 3'd4
    } st_size_e;

    // branch_i[1:0] compare kind; branch_i[2] inverts the outcome
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_LT   = 2'b10;
    localparam logic [1:0] BR_LTU  = 2'b11;

    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_DIV  = 2'd1,
        RES_PC4  = 2'd2,
        RES_KEEP = 2'd3
    } res_sel_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Number of bytes written by a store size code (0 means no store)
    function automatic int st_bytes(input logic [2:0] size);
        case (st_size_e'(size))
            ST_B:    return 1;
            ST_H:    return 2;
            ST_W:    return 4;
            ST_D:    return 8;
            default: return 0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_stage_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ex_div                                                                 |
// | Iterative restoring divider, one quotient bit per cycle, with          |
// | start/busy/done handshake and flush abort. Signed ops divide the       |
// | magnitudes and fix signs in the DONE state.                            |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module ex_div
    import ex_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            hold_i,
    input  logic            flush_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);

    div_state_e      state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic            rem_sel_q;
    logic            neg_a_q;
    logic            neg_q_q;
    logic            div0_q;

    logic            start;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN:0]   shift;
    logic [XLEN:0]   diff;
    logic            ge;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    // Operand preparation, one restoring step and final sign correction
    always_comb begin
        start   = start_i && !hold_i && !flush_i;
        neg_a   = !op_i[0] && a_i[XLEN-1];
        neg_b   = !op_i[0] && b_i[XLEN-1];
        mag_a   = neg_a ? -a_i : a_i;
        mag_b   = neg_b ? -b_i : b_i;
        shift   = {rem_q, quo_q[XLEN-1]};
        diff    = shift - {1'b0, dvs_q};
        ge      = !diff[XLEN];
        // divide-by-zero leaves the raw all-ones quotient unsigned
        quo_fix = div0_q ? '1 : (neg_q_q ? -quo_q : quo_q);
        rem_fix = neg_a_q ? -rem_q : rem_q;
    end

    assign busy_o   = (state_q == DIV_BUSY) ||
                      ((state_q == DIV_IDLE) && start && !rst);
    assign done_o   = (state_q == DIV_DONE);
    assign result_o = rem_sel_q ? rem_fix : quo_fix;

    // Divider FSM: latch operands on start, XLEN iterations, hold result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            rem_sel_q <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_q_q   <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        state_q   <= DIV_BUSY;
                        cnt_q     <= '0;
                        quo_q     <= mag_a;
                        rem_q     <= '0;
                        dvs_q     <= mag_b;
                        rem_sel_q <= op_i[1];
                        neg_a_q   <= neg_a;
                        neg_q_q   <= neg_a ^ neg_b;
                        div0_q    <= (b_i == '0);
                    end
                end
                DIV_BUSY: begin
                    if (flush_i) begin
                        state_q <= DIV_IDLE;
                    end else begin
                        quo_q <= {quo_q[XLEN-2:0], ge};
                        rem_q <= ge ? diff[XLEN-1:0] : shift[XLEN-1:0];
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(XLEN - 1)) begin
                            state_q <= DIV_DONE;
                        end
                    end
                end
                DIV_DONE: begin
                    if (flush_i || !hold_i) begin
                        state_q <= DIV_IDLE;
                    end
                end
                default: state_q <= DIV_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ex_mem_stage                                                           |
// | Execute stage (forwarding, ALU, branch compare, store lane steering,   |
// | iterative divider) and the EX/MEM pipeline register.                   |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold_i,
    input  logic            flush_i,
    input  logic [1:0]      fwd1_sel_i,
    input  logic [1:0]      fwd2_sel_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] fwd_mem_i,
    input  logic [XLEN-1:0] fwd_wb_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            a_pc_i,
    input  logic            b_imm_i,
    input  logic [3:0]      alu_ctrl_i,
    input  logic            div_start_i,
    input  logic [1:0]      div_op_i,
    input  logic [1:0]      res_sel_i,
    input  logic [RD_W-1:0] rd_i,
    input  logic            wb_en_i,
    input  logic [2:0]      load_i,
    input  logic [2:0]      store_i,
    input  logic [2:0]      branch_i,
    output logic            ex_busy_o,
    output logic            taken_o,
    output logic [XLEN-1:0] alu_o,
    output logic [XLEN-1:0] st_data_o,
    output logic [XLEN/8-1:0] bweb_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] res_mem_o,
    output logic [RD_W-1:0] rd_mem_o,
    output logic            wb_en_mem_o,
    output logic [2:0]      load_mem_o
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0] rs1_f;
    logic [XLEN-1:0] rs2_f;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu;
    logic            cmp;
    logic            div_busy;
    logic            div_done;
    logic [XLEN-1:0] div_res;
    logic [XLEN-1:0] res_d;
    int              sz;
    int              off;

    logic [XLEN-1:0] res_mem_q;
    logic [RD_W-1:0] rd_mem_q;
    logic            wb_en_mem_q;
    logic [2:0]      load_mem_q;

    // Forwarding muxes first, then the PC/immediate operand selection
    always_comb begin
        case (fwd1_sel_i)
            FWD_MEM: rs1_f = fwd_mem_i;
            FWD_WB:  rs1_f = fwd_wb_i;
            default: rs1_f = rs1_i;
        endcase
        case (fwd2_sel_i)
            FWD_MEM: rs2_f = fwd_mem_i;
            FWD_WB:  rs2_f = fwd_wb_i;
            default: rs2_f = rs2_i;
        endcase
        op_a = a_pc_i  ? pc_i  : rs1_f;
        op_b = b_imm_i ? imm_i : rs2_f;
    end

    // ALU
    always_comb begin
        case (alu_op_e'(alu_ctrl_i))
            ALU_ADD:   alu = op_a + op_b;
            ALU_SUB:   alu = op_a - op_b;
            ALU_SLL:   alu = op_a << op_b[SW-1:0];
            ALU_SLT:   alu = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  alu = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:   alu = op_a ^ op_b;
            ALU_SRL:   alu = op_a >> op_b[SW-1:0];
            ALU_SRA:   alu = $unsigned($signed(op_a) >>> op_b[SW-1:0]);
            ALU_OR:    alu = op_a | op_b;
            ALU_AND:   alu = op_a & op_b;
            ALU_PASSB: alu = op_b;
            default:   alu = '0;
        endcase
    end

    assign alu_o = alu;

    // Branch compare on forwarded register values (never PC/imm)
    always_comb begin
        case (branch_i[1:0])
            BR_EQ:   cmp = (rs1_f == rs2_f);
            BR_LT:   cmp = ($signed(rs1_f) < $signed(rs2_f));
            BR_LTU:  cmp = (rs1_f < rs2_f);
            default: cmp = 1'b0;
        endcase
        taken_o = (branch_i[1:0] != BR_NONE) && (cmp ^ branch_i[2]);
    end

    // Store lane steering: shift data to the byte offset, enable lanes low
    always_comb begin
        sz         = st_bytes(store_i);
        off        = int'(alu[OW-1:0]);
        st_data_o  = rs2_f;
        bweb_o     = '1;
        misalign_o = 1'b0;
        if (sz != 0) begin
            st_data_o = rs2_f << {alu[OW-1:0], 3'b000};
            if ((sz > NB) || ((off % sz) != 0)) begin
                misalign_o = 1'b1;
            end else begin
                for (int i = 0; i < NB; i++) begin
                    if ((i >= off) && (i < off + sz)) begin
                        bweb_o[i] = 1'b0;
                    end
                end
            end
        end
    end

    ex_div #(
        .XLEN (XLEN)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start_i  (div_start_i),
        .hold_i   (hold_i),
        .flush_i  (flush_i),
        .op_i     (div_op_i),
        .a_i      (rs1_f),
        .b_i      (rs2_f),
        .busy_o   (div_busy),
        .done_o   (div_done),
        .result_o (div_res)
    );

    assign ex_busy_o = div_busy;

    // Result select for the MEM register; 'keep' and an unfinished divide hold the old value
    always_comb begin
        case (res_sel_e'(res_sel_i))
            RES_ALU: res_d = alu;
            RES_DIV: res_d = div_done ? div_res : res_mem_q;
            RES_PC4: res_d = pc_i + XLEN'(4);
            default: res_d = res_mem_q;
        endcase
    end

    // EX/MEM register: hold freezes, flush/busy inject a bubble, else load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_mem_q   <= '0;
            rd_mem_q    <= '0;
            wb_en_mem_q <= 1'b0;
            load_mem_q  <= '0;
        end else if (hold_i) begin
            if (flush_i) begin
                wb_en_mem_q <= 1'b0;
                load_mem_q  <= '0;
            end
        end else if (flush_i || div_busy) begin
            rd_mem_q    <= '0;
            wb_en_mem_q <= 1'b0;
            load_mem_q  <= '0;
        end else begin
            res_mem_q   <= res_d;
            rd_mem_q    <= rd_i;
            wb_en_mem_q <= wb_en_i;
            load_mem_q  <= load_i;
        end
    end

    assign res_mem_o   = res_mem_q;
    assign rd_mem_o    = rd_mem_q;
    assign wb_en_mem_o = wb_en_mem_q;
    assign load_mem_o  = load_mem_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ex_mem_stage                                                        |
// | Randomised self-checking bench for ex_mem_stage (XLEN=32 instance plus |
// | an XLEN=64 instance for wide store steering).                          |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold_i, flush_i;
    logic [1:0]  fwd1_sel_i, fwd2_sel_i;
    logic [31:0] rs1_i, rs2_i, fwd_mem_i, fwd_wb_i, pc_i, imm_i;
    logic        a_pc_i, b_imm_i;
    logic [3:0]  alu_ctrl_i;
    logic        div_start_i;
    logic [1:0]  div_op_i, res_sel_i;
    logic [5:0]  rd_i;
    logic        wb_en_i;
    logic [2:0]  load_i, store_i, branch_i;

    logic        ex_busy_o, taken_o, misalign_o, wb_en_mem_o;
    logic [31:0] alu_o, st_data_o, res_mem_o;
    logic [3:0]  bweb_o;
    logic [5:0]  rd_mem_o;
    logic [2:0]  load_mem_o;

    logic [63:0] rs1_64, rs2_64, imm_64;
    logic [2:0]  store_64;
    logic        busy64, taken64, mis64, wb64;
    logic [63:0] alu64, st64, res64;
    logic [7:0]  bweb64;
    logic [5:0]  rd64;
    logic [2:0]  load64;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_res;

    always #5 clk = ~clk;

    ex_mem_stage #(.XLEN(32), .RD_W(6)) u_dut (
        .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i),
        .fwd1_sel_i(fwd1_sel_i), .fwd2_sel_i(fwd2_sel_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .fwd_mem_i(fwd_mem_i), .fwd_wb_i(fwd_wb_i),
        .pc_i(pc_i), .imm_i(imm_i), .a_pc_i(a_pc_i), .b_imm_i(b_imm_i),
        .alu_ctrl_i(alu_ctrl_i), .div_start_i(div_start_i), .div_op_i(div_op_i),
        .res_sel_i(res_sel_i), .rd_i(rd_i), .wb_en_i(wb_en_i), .load_i(load_i),
        .store_i(store_i), .branch_i(branch_i),
        .ex_busy_o(ex_busy_o), .taken_o(taken_o), .alu_o(alu_o),
        .st_data_o(st_data_o), .bweb_o(bweb_o), .misalign_o(misalign_o),
        .res_mem_o(res_mem_o), .rd_mem_o(rd_mem_o), .wb_en_mem_o(wb_en_mem_o),
        .load_mem_o(load_mem_o)
    );

    ex_mem_stage #(.XLEN(64), .RD_W(6)) u_dut64 (
        .clk(clk), .rst(rst), .hold_i(1'b0), .flush_i(1'b0),
        .fwd1_sel_i(2'b00), .fwd2_sel_i(2'b00),
        .rs1_i(rs1_64), .rs2_i(rs2_64), .fwd_mem_i(64'd0), .fwd_wb_i(64'd0),
        .pc_i(64'd0), .imm_i(imm_64), .a_pc_i(1'b0), .b_imm_i(1'b1),
        .alu_ctrl_i(4'd0), .div_start_i(1'b0), .div_op_i(2'b00),
        .res_sel_i(2'b11), .rd_i(6'd0), .wb_en_i(1'b0), .load_i(3'd0),
        .store_i(store_64), .branch_i(3'd0),
        .ex_busy_o(busy64), .taken_o(taken64), .alu_o(alu64),
        .st_data_o(st64), .bweb_o(bweb64), .misalign_o(mis64),
        .res_mem_o(res64), .rd_mem_o(rd64), .wb_en_mem_o(wb64),
        .load_mem_o(load64)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_fwd(input logic [1:0] s, input logic [31:0] r,
                                          input logic [31:0] m, input logic [31:0] w);
        if (s == 2'b01) return m;
        if (s == 2'b10) return w;
        return r;
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << sh;
            4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a >> sh;
            4'd7:  return $unsigned($signed(a) >>> sh);
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'd0: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $unsigned($signed(a) / $signed(b));
            end
            2'd1: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd2: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return $unsigned($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic idle_inputs;
        hold_i = 0; flush_i = 0; fwd1_sel_i = 0; fwd2_sel_i = 0;
        rs1_i = 0; rs2_i = 0; fwd_mem_i = 0; fwd_wb_i = 0; pc_i = 0; imm_i = 0;
        a_pc_i = 0; b_imm_i = 0; alu_ctrl_i = 0; div_start_i = 0; div_op_i = 0;
        res_sel_i = 2'b11; rd_i = 0; wb_en_i = 0; load_i = 0; store_i = 0; branch_i = 0;
        rs1_64 = 0; rs2_64 = 0; imm_64 = 0; store_64 = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        idle_inputs();
        rst = 1;
        div_start_i = 1;
        @(negedge clk);
        checks++; if (ex_busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", ex_busy_o); end
        checks++; if (res_mem_o !== 32'd0) begin errors++; $display("FAIL rst_res got %h want 0", res_mem_o); end
        checks++; if (rd_mem_o !== 6'd0) begin errors++; $display("FAIL rst_rd got %h want 0", rd_mem_o); end
        checks++; if (wb_en_mem_o !== 1'b0) begin errors++; $display("FAIL rst_wb got %b want 0", wb_en_mem_o); end
        checks++; if (load_mem_o !== 3'd0) begin errors++; $display("FAIL rst_load got %h want 0", load_mem_o); end
        rst = 0;
        div_start_i = 0;
        exp_res = 32'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_random;
        logic [31:0] a, b, ea;
        logic [1:0]  rs;
        for (int n = 0; n < 24; n++) begin
            fwd1_sel_i = 2'($urandom_range(0, 3)); fwd2_sel_i = 2'($urandom_range(0, 3));
            rs1_i = $urandom; rs2_i = $urandom; fwd_mem_i = $urandom; fwd_wb_i = $urandom;
            pc_i = (n == 0) ? 32'hFFFF_FFFC : $urandom; imm_i = $urandom;
            a_pc_i = 1'($urandom); b_imm_i = 1'($urandom);
            alu_ctrl_i = 4'($urandom_range(0, 15));
            rs = 2'($urandom_range(0, 2));
            res_sel_i = (rs == 2'd1) ? 2'd3 : rs;
            if (n == 0) res_sel_i = 2'd2;
            rd_i = 6'($urandom); wb_en_i = 1'($urandom); load_i = 3'($urandom);
            a = a_pc_i ? pc_i : m_fwd(fwd1_sel_i, rs1_i, fwd_mem_i, fwd_wb_i);
            b = b_imm_i ? imm_i : m_fwd(fwd2_sel_i, rs2_i, fwd_mem_i, fwd_wb_i);
            ea = m_alu(alu_ctrl_i, a, b);
            if (res_sel_i == 2'd0) exp_res = ea;
            else if (res_sel_i == 2'd2) exp_res = pc_i + 32'd4;
            @(negedge clk);
            checks++; if (alu_o !== ea) begin errors++; $display("FAIL alu op=%0d got %h want %h", alu_ctrl_i, alu_o, ea); end
            @(posedge clk); #1;
            checks++; if (res_mem_o !== exp_res) begin errors++; $display("FAIL res_mem sel=%0d got %h want %h", res_sel_i, res_mem_o, exp_res); end
            checks++; if (rd_mem_o !== rd_i) begin errors++; $display("FAIL rd_mem got %h want %h", rd_mem_o, rd_i); end
            checks++; if (wb_en_mem_o !== wb_en_i) begin errors++; $display("FAIL wb_mem got %b want %b", wb_en_mem_o, wb_en_i); end
            checks++; if (load_mem_o !== load_i) begin errors++; $display("FAIL load_mem got %h want %h", load_mem_o, load_i); end
        end
        idle_inputs();
    endtask

    task automatic test_branch;
        logic [31:0] a, b;
        logic        c, et;
        for (int n = 0; n < 20; n++) begin
            fwd1_sel_i = 2'($urandom_range(0, 3)); fwd2_sel_i = 2'($urandom_range(0, 3));
            rs1_i = $urandom; rs2_i = ($urandom_range(0, 3) == 0) ? rs1_i : $urandom;
            fwd_mem_i = $urandom; fwd_wb_i = $urandom;
            a_pc_i = 1'($urandom); b_imm_i = 1'($urandom); pc_i = $urandom; imm_i = $urandom;
            branch_i = 3'($urandom_range(0, 7));
            a = m_fwd(fwd1_sel_i, rs1_i, fwd_mem_i, fwd_wb_i);
            b = m_fwd(fwd2_sel_i, rs2_i, fwd_mem_i, fwd_wb_i);
            case (branch_i[1:0])
                2'b01: c = (a == b);
                2'b10: c = ($signed(a) < $signed(b));
                2'b11: c = (a < b);
                default: c = 1'b0;
            endcase
            et = (branch_i[1:0] == 2'b00) ? 1'b0 : (c ^ branch_i[2]);
            @(negedge clk);
            checks++; if (taken_o !== et) begin errors++; $display("FAIL taken br=%0d got %b want %b", branch_i, taken_o, et); end
            @(posedge clk); #1;
        end
        idle_inputs();
        rs1_i = 32'hFFFF_FFFF; rs2_i = 32'h0000_0005; fwd_wb_i = 32'd1; fwd2_sel_i = 2'b10;
        branch_i = 3'b011;
        @(negedge clk);
        checks++; if (taken_o !== 1'b0) begin errors++; $display("FAIL bltu_fwd got %b want 0", taken_o); end
        branch_i = 3'b111;
        @(negedge clk);
        checks++; if (taken_o !== 1'b1) begin errors++; $display("FAIL bgeu_fwd got %b want 1", taken_o); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_store;
        logic [31:0] addr, est;
        logic [3:0]  ebw;
        logic        emis;
        int          sz, o;
        b_imm_i = 1; alu_ctrl_i = 4'd0;
        for (int n = 0; n < 20; n++) begin
            rs1_i = $urandom; imm_i = $urandom_range(0, 15); rs2_i = $urandom;
            store_i = 3'($urandom_range(0, 7));
            addr = rs1_i + imm_i;
            sz = (store_i >= 1 && store_i <= 4) ? (1 << (store_i - 1)) : 0;
            o = int'(addr % 4);
            if (sz == 0) begin
                est = rs2_i; ebw = 4'hF; emis = 0;
            end else begin
                est = rs2_i << (8 * o);
                emis = (sz > 4) || ((o % sz) != 0);
                ebw = emis ? 4'hF : 4'(~(((1 << sz) - 1) << o));
            end
            @(negedge clk);
            checks++; if (bweb_o !== ebw) begin errors++; $display("FAIL bweb st=%0d a=%h got %b want %b", store_i, addr, bweb_o, ebw); end
            checks++; if (st_data_o !== est) begin errors++; $display("FAIL st_data st=%0d got %h want %h", store_i, st_data_o, est); end
            checks++; if (misalign_o !== emis) begin errors++; $display("FAIL misalign st=%0d a=%h got %b want %b", store_i, addr, misalign_o, emis); end
            @(posedge clk); #1;
        end
        rs1_i = 32'h1000; imm_i = 32'd2; rs2_i = 32'hAABB_CCDD; store_i = 3'd3;
        rs1_64 = 64'h1000; imm_64 = 64'd6; rs2_64 = 64'h1234; store_64 = 3'd2;
        @(negedge clk);
        checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL sw_mis got %b want 1", misalign_o); end
        checks++; if (bweb_o !== 4'b1111) begin errors++; $display("FAIL sw_bweb got %b want 1111", bweb_o); end
        checks++; if (bweb64 !== 8'b0011_1111) begin errors++; $display("FAIL sh64_bweb got %b want 00111111", bweb64); end
        checks++; if (st64 !== 64'h1234_0000_0000_0000) begin errors++; $display("FAIL sh64_data got %h want 1234000000000000", st64); end
        checks++; if (mis64 !== 1'b0) begin errors++; $display("FAIL sh64_mis got %b want 0", mis64); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_mem_ctrl;
        rd_i = 6'd9; wb_en_i = 1; load_i = 3'd3; rs1_i = 32'h55; alu_ctrl_i = 4'd0; res_sel_i = 2'd0;
        exp_res = 32'h55;
        @(posedge clk); #1;
        hold_i = 1; rd_i = 6'd4; load_i = 3'd1; rs1_i = 32'h77;
        @(posedge clk); #1;
        checks++; if (res_mem_o !== 32'h55 || rd_mem_o !== 6'd9 || wb_en_mem_o !== 1'b1 || load_mem_o !== 3'd3) begin
            errors++; $display("FAIL hold_freeze got res=%h rd=%0d wb=%b ld=%0d want 55 9 1 3", res_mem_o, rd_mem_o, wb_en_mem_o, load_mem_o); end
        flush_i = 1;
        @(posedge clk); #1;
        checks++; if (wb_en_mem_o !== 1'b0 || load_mem_o !== 3'd0) begin
            errors++; $display("FAIL hold_flush got wb=%b ld=%0d want 0 0", wb_en_mem_o, load_mem_o); end
        checks++; if (rd_mem_o !== 6'd9 || res_mem_o !== 32'h55) begin
            errors++; $display("FAIL hold_flush_keep got rd=%0d res=%h want 9 55", rd_mem_o, res_mem_o); end
        hold_i = 0; wb_en_i = 1;
        @(posedge clk); #1;
        checks++; if (rd_mem_o !== 6'd0 || wb_en_mem_o !== 1'b0 || res_mem_o !== 32'h55) begin
            errors++; $display("FAIL flush_bubble got rd=%0d wb=%b res=%h want 0 0 55", rd_mem_o, wb_en_mem_o, res_mem_o); end
        idle_inputs();
    endtask

    task automatic do_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold_n);
        int   cnt;
        logic done;
        logic [31:0] old;
        old = exp_res;
        rs1_i = a; rs2_i = b; div_op_i = op; div_start_i = 1; res_sel_i = 2'd1;
        rd_i = 6'd17; wb_en_i = 1;
        cnt = 0; done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (ex_busy_o) cnt++; else done = 1;
        end
        checks++; if (!done || cnt != 33) begin errors++; $display("FAIL div_busy_cycles got %0d want 33", cnt); end
        checks++; if (wb_en_mem_o !== 1'b0) begin errors++; $display("FAIL div_bubble got %b want 0", wb_en_mem_o); end
        if (hold_n > 0) begin
            hold_i = 1;
            for (int k = 0; k < hold_n; k++) begin
                @(posedge clk); #1;
                checks++; if (res_mem_o !== old) begin errors++; $display("FAIL div_hold got %h want %h", res_mem_o, old); end
            end
            hold_i = 0;
        end
        @(posedge clk); #1;
        div_start_i = 0; res_sel_i = 2'd3; wb_en_i = 0;
        exp_res = m_div(op, a, b);
        checks++; if (res_mem_o !== exp_res) begin errors++; $display("FAIL div op=%0d a=%h b=%h got %h want %h", op, a, b, res_mem_o, exp_res); end
        checks++; if (wb_en_mem_o !== 1'b1 || rd_mem_o !== 6'd17) begin errors++; $display("FAIL div_wb got wb=%b rd=%0d want 1 17", wb_en_mem_o, rd_mem_o); end
    endtask

    task automatic test_div;
        do_div(2'd0, 32'hFFFF_FFF9, 32'd2, 0);
        do_div(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
        do_div(2'd1, 32'h1234_5678, 32'd0, 0);
        do_div(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_div(2'd2, 32'hDEAD_BEEF, 32'd0, 3);
        for (int n = 0; n < 4; n++) begin
            do_div(2'($urandom_range(0, 3)), $urandom, $urandom >> $urandom_range(0, 28), 0);
        end
        idle_inputs();
    endtask

    task automatic test_div_flush;
        rs1_i = 32'd100; rs2_i = 32'd7; div_op_i = 2'd1; div_start_i = 1; res_sel_i = 2'd1; wb_en_i = 1; rd_i = 6'd3;
        for (int c = 0; c < 10; c++) @(negedge clk);
        flush_i = 1; div_start_i = 0;
        @(posedge clk); #1;
        flush_i = 0;
        checks++; if (ex_busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", ex_busy_o); end
        checks++; if (wb_en_mem_o !== 1'b0 || res_mem_o !== exp_res) begin errors++; $display("FAIL flush_mem got wb=%b res=%h want 0 %h", wb_en_mem_o, res_mem_o, exp_res); end
        @(posedge clk); #1;
        checks++; if (ex_busy_o !== 1'b0 || res_mem_o !== exp_res) begin errors++; $display("FAIL flush_idle got busy=%b res=%h want 0 %h", ex_busy_o, res_mem_o, exp_res); end
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        rs1_i = 32'd1000; rs2_i = 32'd3; div_op_i = 2'd1; div_start_i = 1; res_sel_i = 2'd1; wb_en_i = 1;
        for (int c = 0; c < 5; c++) @(negedge clk);
        rst = 1;
        #1;
        checks++; if (ex_busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", ex_busy_o); end
        checks++; if (res_mem_o !== 32'd0 || wb_en_mem_o !== 1'b0) begin errors++; $display("FAIL rst_mid_mem got res=%h wb=%b want 0 0", res_mem_o, wb_en_mem_o); end
        @(negedge clk);
        rst = 0; idle_inputs();
        exp_res = 32'd0;
        @(posedge clk); #1;
        checks++; if (ex_busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got %b want 0", ex_busy_o); end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu_random();
        test_branch();
        test_store();
        test_mem_ctrl();
        test_div();
        test_div_flush();
        do_div(2'd3, 32'd100, 32'd7, 0);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
